// File: rtl/map_i_loader_pkg.sv
// Shared map definitions: word layout, loader states and the built-in map_i table.
package map_pkg;

  localparam int BW_NUM = 6;
  localparam int MAP_W  = 2;
  localparam int WORD_W = BW_NUM * MAP_W;

  typedef logic [WORD_W-1:0] map_word_t;

  typedef enum logic [1:0] {LOAD, PEND, DISCARD} load_state_t;

  // Power-up map_i table: slot k of entry idx holds ((idx >> k) ^ k) mod 4.
  function automatic map_word_t map_i_word(input int unsigned idx);
    map_word_t w;
    w = '0;
    for (int k = 0; k < BW_NUM; k++) begin
      w[MAP_W*k +: MAP_W] = MAP_W'((idx >> k) ^ unsigned'(k));
    end
    return w;
  endfunction

endpackage

// File: rtl/map_i_loader_if.sv
// Valid/ready stream carrying packed map words into the loader.
interface map_load_if;
  import map_pkg::*;

  logic      s_valid;
  logic      s_ready;
  map_word_t s_data;
  logic      s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/map_i_loader_ram.sv
// Ping-pong map storage: one write port, one registered read port, address {bank,idx}.
module map_bank_ram
  import map_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  map_word_t       i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output map_word_t       o_rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef logic [DEPTH-1:0][WORD_W-1:0] mem_t;

  // Init hook: both banks start as the map_i table, so the mapper has a valid map before any load.
  function automatic mem_t f_init();
    mem_t m;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = map_i_word(unsigned'(i % (DEPTH / 2)));
    end
    return m;
  endfunction

  mem_t      r_mem = f_init();
  map_word_t r_rdata;

  // Write port; contents survive reset so the active bank stays valid.
  always @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; a disabled read holds the last word.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/map_i_loader.sv
// Runtime subcarrier-map loader: fills the shadow bank from a stream and swaps banks on a frame strobe.
module map_i_loader
  import map_pkg::*;
#(
  parameter int depht_ram = 10,
  parameter int fftsize   = 1024,
  parameter int Num_bw    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  map_load_if.slave            s,
  input  logic                 swap_en,
  input  logic [depht_ram-1:0] addr,
  input  logic [2:0]           index_bw,
  output logic [1:0]           odat,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 active_bank
);

  load_state_t          r_state;
  logic [depht_ram-1:0] r_wr_cnt;
  logic                 r_active;
  logic                 r_done;
  logic                 r_err;
  logic                 r_ready;

  logic                 w_beat;
  logic                 w_we;
  logic                 w_cnt_last;
  logic                 w_re;
  map_word_t            w_map_data;
  logic [1:0]           w_odat;

  assign w_beat     = s.s_valid & r_ready;
  assign w_we       = w_beat & (r_state == LOAD) & rst_n;
  assign w_cnt_last = (r_wr_cnt == depht_ram'(fftsize - 1));
  assign w_re       = ({1'b0, addr} < (depht_ram + 1)'(fftsize));

  map_bank_ram #(.AW(depht_ram + 1)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr ({~r_active, r_wr_cnt}),
    .i_wdata (s.s_data),
    .i_re    (w_re),
    .i_raddr ({r_active, addr}),
    .o_rdata (w_map_data)
  );

  // Load FSM: counts beats into the shadow bank, rejects bad lengths, commits on swap_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= LOAD;
      r_wr_cnt <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_beat) begin
            if (w_cnt_last) begin
              r_wr_cnt <= '0;
              if (s.s_last) begin
                r_state <= PEND;
                r_ready <= 1'b0;
              end else begin
                r_err   <= 1'b1;
                r_state <= DISCARD;
              end
            end else if (s.s_last) begin
              r_err    <= 1'b1;
              r_wr_cnt <= '0;
            end else begin
              r_wr_cnt <= r_wr_cnt + depht_ram'(1);
            end
          end
        end
        DISCARD: begin
          if (w_beat && s.s_last) r_state <= LOAD;
        end
        PEND: begin
          if (swap_en) begin
            r_active <= ~r_active;
            r_done   <= 1'b1;
            r_state  <= LOAD;
            r_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= LOAD;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Bandwidth slice of the registered map word; unused selects read as zero.
  always_comb begin
    w_odat = 2'b00;
    for (int k = 0; k < Num_bw; k++) begin
      if (index_bw == 3'(k)) w_odat = w_map_data[2*k +: 2];
    end
  end

  assign s.s_ready   = r_ready;
  assign odat        = w_odat;
  assign load_done   = r_done;
  assign load_err    = r_err;
  assign active_bank = r_active;

endmodule

// File: tb/tb_map_i_loader.sv
// Bench for map_i_loader: directed tables, multi-cycle corner sequences and random traffic against a model.
module tb_map_i_loader;
  import map_pkg::*;

  localparam int FFT = 1024;

  logic       clk = 1'b0;
  logic       rst_n, swap_en, load_done, load_err, active_bank;
  logic [9:0] addr;
  logic [2:0] index_bw;
  logic [1:0] odat;

  // Second instance with a short bank so out-of-range addresses are reachable.
  logic       rst2_n, swap2, done2, err2, act2;
  logic [9:0] addr2;
  logic [2:0] idx2;
  logic [1:0] odat2;

  map_load_if lif ();
  map_load_if lif2 ();

  always #5 clk = ~clk;

  map_i_loader #(.depht_ram(10), .fftsize(FFT), .Num_bw(6)) dut (
    .clk(clk), .rst_n(rst_n), .s(lif.slave), .swap_en(swap_en), .addr(addr),
    .index_bw(index_bw), .odat(odat), .load_done(load_done), .load_err(load_err),
    .active_bank(active_bank));

  map_i_loader #(.depht_ram(10), .fftsize(1000), .Num_bw(6)) dut_small (
    .clk(clk), .rst_n(rst2_n), .s(lif2.slave), .swap_en(swap2), .addr(addr2),
    .index_bw(idx2), .odat(odat2), .load_done(done2), .load_err(err2),
    .active_bank(act2));

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model state
  logic [11:0] m_mem [0:2*FFT-1];
  int          m_act, m_cnt;
  bit          m_pend, m_disc, m_done, m_err;
  logic [11:0] m_map;

  typedef struct { logic [9:0] a; logic [2:0] bw; logic [1:0] exp; } vec_t;
  vec_t vecs [8];

  function automatic logic [11:0] tbl(int idx);
    logic [11:0] w;
    for (int k = 0; k < 6; k++) w[2*k +: 2] = 2'(((idx / (1 << k)) ^ k) % 4);
    return w;
  endfunction

  function automatic logic [1:0] slice(logic [11:0] w, int bw);
    if (bw >= 6) return 2'b00;
    return 2'((w >> (2 * bw)) % 4);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  function automatic void model_step();
    if (!rst_n) begin
      m_act = 0; m_cnt = 0; m_pend = 0; m_disc = 0; m_map = '0; m_done = 0; m_err = 0;
      return;
    end
    m_done = 0; m_err = 0;
    if (int'(addr) < FFT) m_map = m_mem[m_act * FFT + int'(addr)];
    if (m_pend) begin
      if (swap_en) begin m_act = 1 - m_act; m_done = 1; m_pend = 0; end
    end else if (lif.s_valid) begin
      if (m_disc) begin
        if (lif.s_last) m_disc = 0;
      end else begin
        m_mem[(1 - m_act) * FFT + m_cnt] = lif.s_data;
        if (m_cnt == FFT - 1) begin
          m_cnt = 0;
          if (lif.s_last) m_pend = 1;
          else begin m_err = 1; m_disc = 1; end
        end else if (lif.s_last) begin
          m_err = 1; m_cnt = 0;
        end else m_cnt++;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("s_ready", lif.s_ready, !m_pend);
    chk("load_done", load_done, m_done);
    chk("load_err", load_err, m_err);
    chk("active_bank", active_bank, m_act[0]);
    chk("odat", odat, slice(m_map, int'(index_bw)));
  endtask

  task automatic do_load(int n, int mode, int gap_pct, bit with_last, bit swap_last);
    for (int b = 0; b < n; b++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        lif.s_valid = 1'b0; tick();
      end
      lif.s_valid = 1'b1;
      lif.s_data  = (mode == 0) ? 12'(b) : (mode == 1) ? 12'(b) ^ 12'hA5A : 12'($urandom);
      lif.s_last  = with_last && (b == n - 1);
      swap_en     = swap_last && (b == n - 1);
      tick();
    end
    lif.s_valid = 1'b0; lif.s_last = 1'b0; swap_en = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_swap();
    swap_en = 1'b1; tick(); swap_en = 1'b0;
  endtask

  initial begin
    logic [1:0] saved;
    int         act0;

    for (int i = 0; i < 2 * FFT; i++) m_mem[i] = tbl(i % FFT);
    lif.s_valid = 0; lif.s_data = '0; lif.s_last = 0;
    lif2.s_valid = 0; lif2.s_data = '0; lif2.s_last = 0;
    swap_en = 0; swap2 = 0; addr = '0; index_bw = '0; addr2 = '0; idx2 = '0;
    rst_n = 0; rst2_n = 0;
    @(negedge clk);
    idle(2);
    chk("rst_odat", odat, 2'b00);
    chk("rst_ready", lif.s_ready, 1'b1);
    chk("rst_active", active_bank, 1'b0);
    rst_n = 1; rst2_n = 1;

    // 1: power-up table, one-cycle addr latency, combinational index_bw
    for (int a = 0; a < FFT; a++) begin
      addr = 10'(a);
      tick();
      for (int i = 0; i < 8; i++) begin
        index_bw = 3'(i);
        #1 chk("t1_sweep", odat, slice(tbl(a), i));
      end
    end

    // Small instance: in-range read, out-of-range hold, unused bandwidth select
    addr2 = 10'd3; idx2 = 3'd4;
    tick();
    chk("oor_read", odat2, slice(tbl(3), 4));
    addr2 = 10'd1010;
    tick();
    chk("oor_hold", odat2, slice(tbl(3), 4));
    idx2 = 3'd7;
    #1 chk("oor_bw7", odat2, 2'b00);

    // 2: full load of beat indices, swap ten cycles later
    do_load(FFT, 0, 0, 1, 0);
    idle(10);
    pulse_swap();
    chk("t2_active", active_bank, 1'b1);
    vecs[0] = '{10'd5, 3'd1, 2'b01};
    vecs[1] = '{10'd5, 3'd0, 2'b01};
    vecs[2] = '{10'd1023, 3'd4, 2'b11};
    vecs[3] = '{10'd6, 3'd1, 2'b01};
    vecs[4] = '{10'd12, 3'd1, 2'b11};
    vecs[5] = '{10'd682, 3'd3, 2'b10};
    vecs[6] = '{10'd682, 3'd5, 2'b00};
    vecs[7] = '{10'd682, 3'd7, 2'b00};
    for (int v = 0; v < 8; v++) begin
      addr = vecs[v].a; index_bw = vecs[v].bw;
      tick();
      chk("t2_vec", odat, vecs[v].exp);
    end

    // 3: short load is rejected; active map untouched
    addr = 10'd5; index_bw = 3'd1;
    tick();
    saved = odat;
    do_load(100, 1, 0, 1, 0);
    idle(2);
    chk("t3_active", active_bank, 1'b1);
    chk("t3_odat", odat, saved);

    // 4: overlong load dropped, then a good load commits
    do_load(1030, 1, 0, 1, 0);
    pulse_swap();
    chk("t4_noswap", active_bank, 1'b1);
    do_load(FFT, 1, 20, 1, 0);
    idle(3);
    pulse_swap();
    chk("t4_swap", active_bank, 1'b0);
    addr = 10'd7; index_bw = 3'd2;
    tick();
    chk("t4_data", odat, slice(12'd7 ^ 12'hA5A, 2));

    // 5: swap on the commit beat is ignored; s_ready low while pending
    do_load(FFT, 2, 0, 1, 1);
    chk("t5_noswap", active_bank, 1'b0);
    lif.s_valid = 1'b1; lif.s_data = 12'hFFF;
    idle(5);
    chk("t5_ready", lif.s_ready, 1'b0);
    pulse_swap();
    lif.s_valid = 1'b0;
    chk("t5_swap", active_bank, 1'b1);

    // 6: reset mid-load returns to bank 0
    do_load(500, 1, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    addr = 10'd800; index_bw = 3'd3;
    tick();
    chk("t6_active", active_bank, 1'b0);
    chk("t6_ready", lif.s_ready, 1'b1);
    chk("t6_odat", odat, slice(m_mem[800], 3));

    // Random: loads of random length with gaps, then free-running traffic
    for (int r = 0; r < 4; r++) begin
      do_load(($urandom_range(1) == 0) ? FFT : int'($urandom_range(1, 1100)), 2, 15, 1, 0);
      idle(int'($urandom_range(1, 5)));
      pulse_swap();
      addr = 10'($urandom); index_bw = 3'($urandom_range(7));
      idle(3);
    end
    act0 = int'(active_bank);
    for (int c = 0; c < 3000; c++) begin
      lif.s_valid = ($urandom_range(1) == 1);
      lif.s_data  = 12'($urandom);
      lif.s_last  = ($urandom_range(299) == 0);
      swap_en     = ($urandom_range(19) == 0);
      addr        = 10'($urandom);
      index_bw    = 3'($urandom_range(7));
      tick();
    end
    lif.s_valid = 0; lif.s_last = 0; swap_en = 0;
    chk("rand_bank", active_bank, m_act[0]);
    if (act0 > 1) chk("rand_act0", act0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
